cla_adder_pipelined: RTL
========================

// Module: cla_adder_pipelined
// PURPOSE
//   Parametrised, pipelined carry-lookahead adder/subtractor. Operands are split into
//   GROUP_W-bit groups. Each group's carry-out is formed by single-level lookahead
//   (co = g3 + p3g2 + p3p2g1 + p3p2p1g0 + p3p2p1p0ci).
//   One group is resolved per pipeline stage, which gives a short, fixed critical path
//   regardless of WIDTH. The block is the datapath adder for wider arithmetic units and
//   uses a valid/ready stream handshake on both sides.
// PARAMETERS
//   WIDTH    8  operand/sum width; must be a multiple of GROUP_W, >= GROUP_W
//   GROUP_W  4  bits per lookahead group (supported: 4)
//   NGRP     WIDTH/GROUP_W (localparam) pipeline stage count = latency in cycles
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block accepts beat this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (ignored when sub=1)
//   sub        in   1      1: compute a + ~b + 1; 0: compute a + b + cin
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//   ovf        out  1      two's-complement overflow: carry into MSB XOR cout
// BEHAVIOUR
// - Reset
//   - One clock; reset is asynchronous and active-high (rst).
//   - While rst=1, all stage valid bits, sum, cout and ovf are 0.
//   - Deassertion is synchronous to clk.
// - Pipeline stages
//   - Stage k (0..NGRP-1) holds: a valid bit, the remaining unprocessed operand bits
//     (skewed), the sum bits resolved so far, and the carry into group k+1.
//   - Stage k computes p=a^b' and g=a&b' per bit of group k, where b' is b, or ~b when
//     sub=1.
//   - It then computes the 4-bit lookahead carry and the group sum, and registers them.
//   - Carry into group 0 is cin, or 1 when sub=1.
// - Advance and handshake
//   - Global advance: adv = !out_valid | out_ready. All stages shift together when adv=1
//     and hold every register when adv=0.
//   - in_ready = adv. This is combinational from out_ready and out_valid, and never
//     depends on in_valid.
//   - A beat is accepted when in_valid & in_ready. Stage 0 loads valid=in_valid whenever
//     adv=1, so bubbles propagate.
//   - out_valid is the valid bit of the last stage. sum/cout/ovf are registered outputs
//     of the last stage.
//   - Outputs are stable while out_valid & !out_ready.
// - Latency and throughput
//   - Latency: NGRP cycles from acceptance to out_valid, with out_ready held 1.
//   - Throughput: 1 beat/cycle.
// - ovf
//   - Uses the carry into the MSB bit of the top group, computed inside the last stage
//     (c_msb = p/g chain within the group).
// - Boundary conditions
//   - Full pipeline with out_ready=0: in_ready=0; no beat is lost or duplicated.
//   - out_ready rising with in_valid=1 in the same cycle: the output drains and the new
//     beat enters in the same edge.
//   - Invalid stages still shift their data; valid=0 marks them don't-care.
//   - rst asserted mid-stream: all in-flight beats are discarded immediately (async).
//     The first beat after release appears NGRP cycles after acceptance.
//   - Wrap-around: sum is modulo 2^WIDTH; the carry out appears only on cout.
// - Invalid parameter values (WIDTH % GROUP_W != 0, or GROUP_W != 4) are rejected at
//   elaboration with $error.
// TESTING (WIDTH=8, latency 2 unless noted)
// - a=8'hFF, b=8'h01, cin=0, sub=0 -> after 2 cycles sum=8'h00, cout=1, ovf=0.
// - a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1. Also a=8'h7F, b=8'h01,
//   sub=0 -> sum=8'h80, cout=0, ovf=1.
// - Back-to-back beats: 16 beats with in_valid=1 and out_ready=1 -> 16 results on
//   consecutive cycles, in order, each matching the golden model (a+b+cin).
// - Backpressure: out_ready=0 for 5 cycles with 3 beats offered.
//   - Required: in_ready drops once both stages are valid.
//   - Required: sum stays stable while stalled.
//   - Required: all 3 results emerge in order after out_ready=1.
// - Reset mid-stream: assert rst with 2 beats in flight.
//   - Required: out_valid=0, sum=0 during reset.
//   - Required: no stale beat emerges after release.
// - WIDTH=32 (latency 8): random 10k beats with random out_ready against the golden
//   model.
//   - Required: zero mismatches.
//   - Required: cout/ovf correct for all-ones and 32'h8000_0000 corner operands.

Source files
------------

// File: rtl/cla_adder_pipelined.sv
// Pipelined carry-lookahead adder/subtractor. One 4-bit lookahead group is
// resolved per stage, so latency is WIDTH/GROUP_W cycles and throughput is
// one beat per cycle. A single global advance stalls every stage at once.

// One pipeline stage: resolves group K and passes the rest of the beat along.
module cla_adder_stage #(
    parameter int WIDTH   = 8,
    parameter int GROUP_W = 4,
    parameter int K       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             c_i,
    input  logic [WIDTH-1:0] s_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             sub_o,
    output logic             c_o,
    output logic [WIDTH-1:0] s_o,
    output logic             ovf_o
);
    logic [GROUP_W-1:0] ga, gb, p, g, gs;
    logic [GROUP_W:0]   c;
    logic [WIDTH-1:0]   s_nxt;

    assign ga = a_i[K*GROUP_W +: GROUP_W];
    // Subtraction inverts B here; the +1 enters as the carry into group 0.
    assign gb = b_i[K*GROUP_W +: GROUP_W] ^ {GROUP_W{sub_i}};
    assign p  = ga ^ gb;
    assign g  = ga & gb;

    // Single-level lookahead: every carry is a flat AND-OR of g/p and c_i.
    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign gs   = p ^ c[GROUP_W-1:0];

    // Merge this group's sum bits into the partially resolved result.
    always_comb begin
        s_nxt = s_i;
        s_nxt[K*GROUP_W +: GROUP_W] = gs;
    end

    // Stage register: shifts on adv (valid or not), holds otherwise.
    // Operands are carried whole; bits of already-resolved groups are ignored downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_o <= 1'b0;
            a_o   <= '0;
            b_o   <= '0;
            sub_o <= 1'b0;
            c_o   <= 1'b0;
            s_o   <= '0;
            ovf_o <= 1'b0;
        end else if (adv) begin
            vld_o <= vld_i;
            a_o   <= a_i;
            b_o   <= b_i;
            sub_o <= sub_i;
            c_o   <= c[GROUP_W];
            s_o   <= s_nxt;
            // Only meaningful in the top group: carry into MSB xor carry out.
            ovf_o <= c[GROUP_W-1] ^ c[GROUP_W];
        end
    end
endmodule

module cla_adder_pipelined #(
    parameter int WIDTH   = 8,
    parameter int GROUP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NGRP = WIDTH / GROUP_W;

    if (GROUP_W != 4 || WIDTH < GROUP_W || (WIDTH % GROUP_W) != 0) begin : g_bad_param
        $error("cla_adder_pipelined: WIDTH must be a multiple of GROUP_W and GROUP_W must be 4");
    end

    // Index k is the input of stage k; index k+1 is its registered output.
    logic [NGRP:0]            vld_pipe, sub_st, c_st, ovf_st;
    logic [NGRP:0][WIDTH-1:0] a_st, b_st, s_st;
    logic                     adv;
    logic                     unused_bits;

    assign vld_pipe[0] = in_valid;
    assign a_st[0]     = a;
    assign b_st[0]     = b;
    assign sub_st[0]   = sub;
    assign c_st[0]     = sub | cin;
    assign s_st[0]     = '0;
    assign ovf_st[0]   = 1'b0;

    // Whole pipe moves unless a valid result is being held for the consumer.
    assign out_valid = vld_pipe[NGRP];
    assign adv       = !out_valid | out_ready;
    assign in_ready  = adv;
    assign sum       = s_st[NGRP];
    assign cout      = c_st[NGRP];
    assign ovf       = ovf_st[NGRP];

    assign unused_bits = ^{a_st[NGRP], b_st[NGRP], sub_st[NGRP], ovf_st[NGRP-1:0]};

    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        cla_adder_stage #(.WIDTH(WIDTH), .GROUP_W(GROUP_W), .K(k)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .adv   (adv),
            .vld_i (vld_pipe[k]),
            .a_i   (a_st[k]),
            .b_i   (b_st[k]),
            .sub_i (sub_st[k]),
            .c_i   (c_st[k]),
            .s_i   (s_st[k]),
            .vld_o (vld_pipe[k+1]),
            .a_o   (a_st[k+1]),
            .b_o   (b_st[k+1]),
            .sub_o (sub_st[k+1]),
            .c_o   (c_st[k+1]),
            .s_o   (s_st[k+1]),
            .ovf_o (ovf_st[k+1])
        );
    end
endmodule
